sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 23 ++
 rtl/sram_arbiter.sv | 143 ++++++++++++++
 tb/tb_sram_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared configuration for the SRAM arbiter.
//   CLOCK_SPEED     : bus clock frequency in Hz (pll_clk_bus domain)
//   ACC_CYCLES_DEF  : default number of bus cycles per SRAM access (2..7)
//   state_t         : arbiter FSM state encodings
//   req_t           : one latched SRAM request (direction, address, write data)
package sram_arbiter_pkg;

  localparam int CLOCK_SPEED    = 50_000_000;
  localparam int ACC_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_ACC = 2'd1,
    ST_DMA_ACC = 2'd2
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [19:0] addr;
    logic [7:0]  data;
  } req_t;

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for an asynchronous 8-bit SRAM.
// The CPU issues single-cycle read/write strobes that land in a one-deep
// pending slot and always win arbitration; the DMA/video requester holds
// iDmaReq with stable fields until its one-cycle oDmaAck. Each access runs
// for exactly ACC_CYCLES bus cycles and is never preempted.
// Ports:
//   iClk, iRst                         bus clock, synchronous active-high reset
//   iCpuRd/iCpuWr/iCpuAddr/iCpuData    CPU strobes (write wins when both set)
//   oCpuData/oCpuValid                 CPU read data + one-cycle valid pulse
//   iDmaReq/iDmaWr/iDmaAddr/iDmaData   DMA request (held until ack)
//   oDmaAck/oDmaData                   DMA completion pulse + read data
//   oSramA/oSramDOut/iSramD/oSramDir   SRAM address and data bus (Dir 1 = drive)
//   oCe1/oCe2/oOe/oWe                  SRAM strobes (Ce2 active high, others low)
//   oOverrun                           pulse when a pending CPU request is lost
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ACC_CYCLES = ACC_CYCLES_DEF
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCpuRd,
  input  logic        iCpuWr,
  input  logic [19:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  output logic [7:0]  oCpuData,
  output logic        oCpuValid,
  input  logic        iDmaReq,
  input  logic        iDmaWr,
  input  logic [19:0] iDmaAddr,
  input  logic [7:0]  iDmaData,
  output logic        oDmaAck,
  output logic [7:0]  oDmaData,
  output logic [19:0] oSramA,
  output logic [7:0]  oSramDOut,
  input  logic [7:0]  iSramD,
  output logic        oSramDir,
  output logic        oCe1,
  output logic        oCe2,
  output logic        oOe,
  output logic        oWe,
  output logic        oOverrun
);

  localparam logic [2:0] LAST = 3'(ACC_CYCLES - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       own_wr;
  req_t       pend;
  logic       pend_vld;

  logic cpu_stb, cpu_any, last, decide, take_cpu, take_dma;
  req_t cpu_new, cpu_eff;

  // A strobe in the deciding cycle is used directly, which gives the
  // one-cycle strobe-to-access latency from IDLE and lets a strobe in the
  // last access cycle chain straight into the next CPU access.
  always_comb begin
    cpu_stb  = iCpuRd | iCpuWr;
    cpu_new  = '{wr: iCpuWr, addr: iCpuAddr, data: iCpuData};
    cpu_eff  = cpu_stb ? cpu_new : pend;
    cpu_any  = cpu_stb | pend_vld;
    last     = (state != ST_IDLE) && (cnt == LAST);
    decide   = (state == ST_IDLE) || last;
    take_cpu = decide && cpu_any;
    take_dma = decide && !cpu_any && iDmaReq;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= ST_IDLE;
      cnt       <= 3'd0;
      own_wr    <= 1'b0;
      pend      <= '0;
      pend_vld  <= 1'b0;
      oCe1      <= 1'b1;
      oCe2      <= 1'b0;
      oOe       <= 1'b1;
      oWe       <= 1'b1;
      oSramDir  <= 1'b0;
      oSramA    <= '0;
      oSramDOut <= '0;
      oCpuData  <= '0;
      oDmaData  <= '0;
      oCpuValid <= 1'b0;
      oDmaAck   <= 1'b0;
      oOverrun  <= 1'b0;
    end else begin
      oCpuValid <= 1'b0;
      oDmaAck   <= 1'b0;
      // The slot is only ever full outside IDLE, so this flags a lost request.
      oOverrun  <= cpu_stb & pend_vld;

      // Pending slot: consumed when a CPU access starts, otherwise refilled.
      if (take_cpu)
        pend_vld <= 1'b0;
      else if (cpu_stb) begin
        pend     <= cpu_new;
        pend_vld <= 1'b1;
      end

      // Completion: capture read data at the end of the last access cycle.
      if (last) begin
        if (state == ST_CPU_ACC) begin
          if (!own_wr) begin
            oCpuData  <= iSramD;
            oCpuValid <= 1'b1;
          end
        end else begin
          oDmaAck <= 1'b1;
          if (!own_wr)
            oDmaData <= iSramD;
        end
      end

      if (take_cpu || take_dma) begin
        state     <= take_cpu ? ST_CPU_ACC : ST_DMA_ACC;
        cnt       <= 3'd0;
        own_wr    <= take_cpu ? cpu_eff.wr   : iDmaWr;
        oSramA    <= take_cpu ? cpu_eff.addr : iDmaAddr;
        oSramDOut <= take_cpu ? cpu_eff.data : iDmaData;
        oSramDir  <= take_cpu ? cpu_eff.wr   : iDmaWr;
        oOe       <= take_cpu ? cpu_eff.wr   : iDmaWr;
        oCe1      <= 1'b0;
        oCe2      <= 1'b1;
        oWe       <= 1'b1;  // first cycle is address setup
      end else if (last) begin
        state    <= ST_IDLE;
        cnt      <= 3'd0;
        oCe1     <= 1'b1;
        oCe2     <= 1'b0;
        oOe      <= 1'b1;
        oWe      <= 1'b1;
        oSramDir <= 1'b0;
      end else if (state != ST_IDLE) begin
        cnt <= cnt + 3'd1;
        oWe <= !own_wr;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with ACC_CYCLES = 2 and a behavioural
// SRAM: reads come from preloaded contents (or earlier writes), writes
// land while CE is active and WE is low.
module tb_sram_arbiter;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iCpuRd, iCpuWr;
  logic [19:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic [7:0]  oCpuData;
  logic        oCpuValid;
  logic        iDmaReq, iDmaWr;
  logic [19:0] iDmaAddr;
  logic [7:0]  iDmaData;
  logic        oDmaAck;
  logic [7:0]  oDmaData;
  logic [19:0] oSramA;
  logic [7:0]  oSramDOut;
  logic [7:0]  iSramD = 8'h00;
  logic        oSramDir, oCe1, oCe2, oOe, oWe, oOverrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [logic [19:0]];

  sram_arbiter #(.ACC_CYCLES(2)) dut (
    .iClk(iClk), .iRst(iRst),
    .iCpuRd(iCpuRd), .iCpuWr(iCpuWr), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
    .oCpuData(oCpuData), .oCpuValid(oCpuValid),
    .iDmaReq(iDmaReq), .iDmaWr(iDmaWr), .iDmaAddr(iDmaAddr), .iDmaData(iDmaData),
    .oDmaAck(oDmaAck), .oDmaData(oDmaData),
    .oSramA(oSramA), .oSramDOut(oSramDOut), .iSramD(iSramD), .oSramDir(oSramDir),
    .oCe1(oCe1), .oCe2(oCe2), .oOe(oOe), .oWe(oWe), .oOverrun(oOverrun)
  );

  always #5 iClk = ~iClk;

  // {Ce1, Ce2, Oe, We, Dir}
  wire [4:0] strb = {oCe1, oCe2, oOe, oWe, oSramDir};
  localparam logic [4:0] S_IDLE = 5'b10110;
  localparam logic [4:0] S_RD   = 5'b01010;
  localparam logic [4:0] S_WR0  = 5'b01111;
  localparam logic [4:0] S_WRN  = 5'b01101;

  function automatic logic [7:0] preload(input logic [19:0] a);
    case (a)
      20'h12345: preload = 8'hA5;
      20'h00100: preload = 8'h5A;
      20'h00200: preload = 8'h77;
      20'h00400: preload = 8'h11;
      20'h00500: preload = 8'h22;
      20'h00700: preload = 8'hEE;
      default:   preload = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] sram_rd(input logic [19:0] a);
    if (mem.exists(a)) sram_rd = mem[a];
    else               sram_rd = preload(a);
  endfunction

  // Read data settles half a cycle after the address changes.
  always @(negedge iClk) iSramD <= sram_rd(oSramA);

  always @(posedge iClk)
    if (!oCe1 && oCe2 && !oWe) mem[oSramA] = oSramDOut;

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu(input logic rd, input logic wr, input logic [19:0] a, input logic [7:0] d);
    iCpuRd = rd; iCpuWr = wr; iCpuAddr = a; iCpuData = d;
  endtask

  initial begin
    iRst = 1'b1;
    cpu(1'b0, 1'b0, 20'h0, 8'h0);
    iDmaReq = 1'b0; iDmaWr = 1'b0; iDmaAddr = 20'h0; iDmaData = 8'h0;
    repeat (3) step();

    // Reset state
    chk("rst_strb",   32'(strb), 32'(S_IDLE));
    chk("rst_addr",   32'(oSramA), 32'h0);
    chk("rst_cpudat", 32'(oCpuData), 32'h0);
    chk("rst_pulses", 32'({oCpuValid, oDmaAck, oOverrun}), 32'h0);
    iRst = 1'b0;
    step();

    // CPU read in IDLE: access on the next two cycles, valid after
    cpu(1'b1, 1'b0, 20'h12345, 8'h00);
    step(); cpu(1'b0, 1'b0, 20'h0, 8'h0);
    chk("rd_c1_strb", 32'(strb), 32'(S_RD));
    chk("rd_c1_addr", 32'(oSramA), 32'h12345);
    chk("rd_c1_vld",  32'(oCpuValid), 32'h0);
    step();
    chk("rd_c2_strb", 32'(strb), 32'(S_RD));
    step();
    chk("rd_done_strb", 32'(strb), 32'(S_IDLE));
    chk("rd_done_vld",  32'(oCpuValid), 32'h1);
    chk("rd_done_data", 32'(oCpuData), 32'hA5);
    step();
    chk("rd_vld_pulse", 32'(oCpuValid), 32'h0);
    chk("rd_data_hold", 32'(oCpuData), 32'hA5);

    // CPU write: WE low only on the second access cycle
    cpu(1'b0, 1'b1, 20'hFFFF0, 8'h3C);
    step(); cpu(1'b0, 1'b0, 20'h0, 8'h0);
    chk("wr_c1_strb", 32'(strb), 32'(S_WR0));
    chk("wr_c1_dout", 32'(oSramDOut), 32'h3C);
    step();
    chk("wr_c2_strb", 32'(strb), 32'(S_WRN));
    step();
    chk("wr_done_strb", 32'(strb), 32'(S_IDLE));
    chk("wr_no_vld",    32'(oCpuValid), 32'h0);
    chk("wr_mem",       32'(sram_rd(20'hFFFF0)), 32'h3C);

    // Continuous DMA read, CPU strobe in the second DMA cycle
    iDmaReq = 1'b1; iDmaWr = 1'b0; iDmaAddr = 20'h00100;
    step();
    chk("dma_c1_strb", 32'(strb), 32'(S_RD));
    chk("dma_c1_addr", 32'(oSramA), 32'h00100);
    step();
    cpu(1'b1, 1'b0, 20'h00200, 8'h00);
    chk("dma_c2_addr", 32'(oSramA), 32'h00100);
    step(); cpu(1'b0, 1'b0, 20'h0, 8'h0);
    chk("dma_ack",      32'(oDmaAck), 32'h1);
    chk("dma_data",     32'(oDmaData), 32'h5A);
    chk("chain_addr",   32'(oSramA), 32'h00200);
    chk("chain_strb",   32'(strb), 32'(S_RD));
    step();
    chk("dma_ack_pulse", 32'(oDmaAck), 32'h0);
    step();
    chk("chain_vld",    32'(oCpuValid), 32'h1);
    chk("chain_data",   32'(oCpuData), 32'h77);
    chk("dma2_addr",    32'(oSramA), 32'h00100);
    chk("dma2_strb",    32'(strb), 32'(S_RD));
    iDmaReq = 1'b0;     // dropped mid-access: must still complete
    step();
    chk("dma2_c2_strb", 32'(strb), 32'(S_RD));
    step();
    chk("dma2_ack",     32'(oDmaAck), 32'h1);
    chk("dma2_idle",    32'(strb), 32'(S_IDLE));

    // DMA write with two back-to-back CPU strobes -> overrun
    iDmaReq = 1'b1; iDmaWr = 1'b1; iDmaAddr = 20'h00300; iDmaData = 8'hC4;
    step();
    chk("dwr_c1_strb", 32'(strb), 32'(S_WR0));
    cpu(1'b1, 1'b0, 20'h00400, 8'h00);
    step();
    chk("dwr_c2_strb", 32'(strb), 32'(S_WRN));
    chk("ovr_none",    32'(oOverrun), 32'h0);
    cpu(1'b1, 1'b0, 20'h00500, 8'h00);
    iDmaReq = 1'b0;
    step(); cpu(1'b0, 1'b0, 20'h0, 8'h0);
    chk("ovr_pulse", 32'(oOverrun), 32'h1);
    chk("dwr_ack",   32'(oDmaAck), 32'h1);
    chk("dwr_mem",   32'(sram_rd(20'h00300)), 32'hC4);
    chk("ovr_addr",  32'(oSramA), 32'h00500);
    step();
    chk("ovr_clear", 32'(oOverrun), 32'h0);
    step();
    chk("ovr_vld",   32'(oCpuValid), 32'h1);
    chk("ovr_data",  32'(oCpuData), 32'h22);
    step();
    chk("ovr_no_second", 32'(strb), 32'(S_IDLE));

    // Simultaneous rd+wr with DMA pending: CPU write first, then DMA read
    cpu(1'b1, 1'b1, 20'h00600, 8'h9E);
    iDmaReq = 1'b1; iDmaWr = 1'b0; iDmaAddr = 20'h00100;
    step(); cpu(1'b0, 1'b0, 20'h0, 8'h0);
    chk("both_strb", 32'(strb), 32'(S_WR0));
    chk("both_addr", 32'(oSramA), 32'h00600);
    step();
    chk("both_c2",   32'(strb), 32'(S_WRN));
    step();
    iDmaReq = 1'b0;
    chk("both_dma_addr", 32'(oSramA), 32'h00100);
    chk("both_dma_strb", 32'(strb), 32'(S_RD));
    chk("both_mem",      32'(sram_rd(20'h00600)), 32'h9E);
    chk("both_no_vld",   32'(oCpuValid), 32'h0);
    step();
    step();
    chk("both_dma_ack",  32'(oDmaAck), 32'h1);

    // Reset during the setup cycle of a CPU write
    cpu(1'b0, 1'b1, 20'h00700, 8'h55);
    step(); cpu(1'b0, 1'b0, 20'h0, 8'h0);
    chk("rstw_c1", 32'(strb), 32'(S_WR0));
    iRst = 1'b1;
    step();
    chk("rstw_strb", 32'(strb), 32'(S_IDLE));
    chk("rstw_addr", 32'(oSramA), 32'h0);
    iRst = 1'b0;
    step();
    chk("rstw_no_vld", 32'(oCpuValid), 32'h0);
    chk("rstw_idle",   32'(strb), 32'(S_IDLE));
    chk("rstw_mem",    32'(sram_rd(20'h00700)), 32'hEE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
